div_sched: RTL and testbench
============================

# div_sched

Multi-cycle divide/modulo sequencer for the execute stage. Accepts one DIV/MOD request at a time from EX and latches its operands. Issues a single start pulse to the shared iterative divider, waits for its completion, and selects the quotient or remainder half. Holds the 32-bit result until the pipeline accepts it, and handles flush, divide-by-zero bypass and a completion watchdog.

## Interface
- `MAX_CYCLES`, default 40: watchdog limit in cycles spent in WAIT or DRAIN.
- `clk` in 1: clock; all state updates on the rising edge.
- `resetn` in 1: reset, asynchronous and active-low.
- `req_valid` in 1: EX holds a valid DIV/MOD op.
- `req_ready` out 1: request accepted this cycle.
- `req_op_mod` in 1: 1 = return remainder, 0 = return quotient.
- `req_signed` in 1: signed operation.
- `req_src1` in 32: dividend.
- `req_src2` in 32: divisor.
- `flush` in 1: cancels the in-flight op.
- `div_en` out 1: one-cycle start pulse to the divider.
- `div_signed` out 1: latched signedness to the divider.
- `div_src1` out 32: latched dividend to the divider.
- `div_src2` out 32: latched divisor to the divider.
- `div_res_valid` in 1: divider completion, one-cycle pulse.
- `div_res` in 64: {quotient[63:32], remainder[31:0]}.
- `res_valid` out 1: result available.
- `res_data` out 32: selected result.
- `res_ready` in 1: consumer takes the result.
- `busy` out 1: state != IDLE.
- `timeout` out 1: one-cycle pulse on watchdog expiry.

## Operation
- States: IDLE, ISSUE, WAIT, DRAIN, DONE.
- `req_ready` = (state==IDLE) & ~flush. Accept = `req_valid` & `req_ready`.
- On accept, latch `req_op_mod`, `req_signed`, `req_src1` and `req_src2`.
  - `req_src2` != 0: go to ISSUE.
  - `req_src2` == 0 (bypass, divider not started): `res_data` = 32'hFFFF_FFFF for DIV, or `req_src1` for MOD; go to DONE.
- ISSUE: `div_en` = 1 for exactly this cycle; go to WAIT. If `flush` is asserted, go to DRAIN, because the divider has still started.
- WAIT:
  - On `div_res_valid`, capture `res_data` = op_mod ? `div_res[31:0]` : `div_res[63:32]` and go to DONE.
  - On `flush` without `div_res_valid`, go to DRAIN.
  - On `flush` together with `div_res_valid`, discard the result and go to IDLE.
- DRAIN: the divider cannot be aborted. Wait for `div_res_valid`, discard it, go to IDLE. New requests are blocked.
- DONE: `res_valid` = 1.
  - `res_ready` takes priority over `flush`: the result is consumed and the block returns to IDLE.
  - `flush` without `res_ready`: drop the result and go to IDLE.
- Watchdog: an 8-bit-or-wider counter clears on entry to WAIT/DRAIN and increments each cycle in WAIT/DRAIN. When it reaches `MAX_CYCLES`, pulse `timeout` for one cycle and go to IDLE with no result.
- `div_res_valid` in IDLE, ISSUE or DONE is ignored.
- `div_src1`, `div_src2` and `div_signed` remain stable from ISSUE until the block leaves WAIT/DRAIN.

## Timing
- Reset values (async, while `resetn`=0): state IDLE; `div_en`, `res_valid`, `timeout` and `busy` = 0; `res_data`, `div_src1` and `div_src2` = 0; `div_signed` = 0; watchdog counter = 0.
- `req_ready` = 1 after reset release, provided `flush` = 0.
- All outputs except `req_ready` are registered or decoded from state only. There is no combinational path from `res_ready` or `div_res_valid` to any output.
- Normal latency: accept at cycle T, `div_en` at T+1, WAIT from T+2. If `div_res_valid` arrives at cycle D, `res_valid` is asserted from D+1. The minimum accept-to-`res_valid` latency is 3 cycles.
- Divide-by-zero: accept at T, `res_valid` at T+1.
- Throughput: one op in flight. The next accept is possible in the cycle after the `res_valid` & `res_ready` handshake.
- Reset asserted mid-operation immediately returns the block to IDLE. The divider is reset on the same `resetn`, so no drain is needed.

## Test plan
- Signed DIV: -7 / 2, divider responds 17 cycles after `div_en` → `res_data` = 32'hFFFF_FFFD. `res_valid` rises the cycle after `div_res_valid`, and `div_en` is high exactly once.
- Unsigned MOD: 32'hFFFF_FFFF % 10 → `res_data` = 5. With `res_ready` held low for 4 cycles, `res_valid` and `res_data` remain stable. `req_ready` = 0 until the cycle after `res_ready`.
- Divide-by-zero: DIV 100/0 → `res_data` = 32'hFFFF_FFFF at T+1, `div_en` never asserted. MOD 100/0 → `res_data` = 100.
- Flush in WAIT (cycle 5 of 17): the block enters DRAIN, `req_ready` stays 0, and `div_res_valid` is discarded (`res_valid` stays 0). IDLE is reached and `req_ready` = 1 the following cycle. Repeat with flush in the same cycle as `div_res_valid`: goes directly to IDLE.
- Watchdog: `MAX_CYCLES`=40 with the divider never responding → `timeout` pulses once, 40 cycles after WAIT entry, and `busy` drops the next cycle.
- Reset pulse (`resetn`=0, asynchronous, mid-WAIT): `busy`, `res_valid` and `div_en` go to 0 immediately, without waiting for a clock edge. After release, a new request completes normally.

Source files
------------

// File: rtl/div_sched_if.sv
// Request, divider and result signals of the divide/modulo sequencer.
// slave is the sequencer's view; master is the surrounding pipeline/divider view.
interface div_sched_if;
  localparam int unsigned XLEN = 32;

  logic              req_valid;
  logic              req_ready;
  logic              req_op_mod;
  logic              req_signed;
  logic [XLEN-1:0]   req_src1;
  logic [XLEN-1:0]   req_src2;
  logic              flush;
  logic              div_en;
  logic              div_signed;
  logic [XLEN-1:0]   div_src1;
  logic [XLEN-1:0]   div_src2;
  logic              div_res_valid;
  logic [2*XLEN-1:0] div_res;
  logic              res_valid;
  logic [XLEN-1:0]   res_data;
  logic              res_ready;

  modport slave (
    input  req_valid, req_op_mod, req_signed, req_src1, req_src2, flush,
           div_res_valid, div_res, res_ready,
    output req_ready, div_en, div_signed, div_src1, div_src2, res_valid, res_data
  );

  modport master (
    output req_valid, req_op_mod, req_signed, req_src1, req_src2, flush,
           div_res_valid, div_res, res_ready,
    input  req_ready, div_en, div_signed, div_src1, div_src2, res_valid, res_data
  );
endinterface

// File: rtl/div_sched.sv
// Divide/modulo sequencer: latches one request, starts the shared iterative divider,
// selects quotient or remainder and holds it until consumed; handles flush and a watchdog.
module div_sched #(
  parameter int unsigned MAX_CYCLES = 40
) (
  input  logic         clk,
  input  logic         resetn,
  div_sched_if.slave   bus,
  output logic         busy,
  output logic         timeout
);
  localparam int unsigned XLEN   = 32;
  localparam int unsigned CNT_RW = $clog2(MAX_CYCLES + 1);
  localparam int unsigned CNT_W  = (CNT_RW > 8) ? CNT_RW : 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic              op_mod_q, op_mod_d;
  logic              div_signed_q, div_signed_d;
  logic [XLEN-1:0]   div_src1_q, div_src1_d;
  logic [XLEN-1:0]   div_src2_q, div_src2_d;
  logic [XLEN-1:0]   res_data_q, res_data_d;
  logic [CNT_W-1:0]  wd_cnt_q, wd_cnt_d;
  logic              div_en_q, div_en_d;
  logic              res_valid_q, res_valid_d;
  logic              busy_q, busy_d;
  logic              timeout_q, timeout_d;
  logic              req_ready_c;
  logic              accept_c;
  logic              wd_expired_c;
  logic              in_wd_d;

  assign req_ready_c  = (state_q == S_IDLE) & ~bus.flush;
  assign accept_c     = bus.req_valid & req_ready_c;
  assign wd_expired_c = (wd_cnt_q == CNT_W'(MAX_CYCLES));

  // Next state, operand latching and result capture
  always_comb begin
    state_d      = state_q;
    op_mod_d     = op_mod_q;
    div_signed_d = div_signed_q;
    div_src1_d   = div_src1_q;
    div_src2_d   = div_src2_q;
    res_data_d   = res_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          op_mod_d     = bus.req_op_mod;
          div_signed_d = bus.req_signed;
          div_src1_d   = bus.req_src1;
          div_src2_d   = bus.req_src2;
          if (bus.req_src2 != '0) begin
            state_d = S_ISSUE;
          end else begin
            // Divide-by-zero never reaches the divider
            res_data_d = bus.req_op_mod ? bus.req_src1 : '1;
            state_d    = S_DONE;
          end
        end
      end
      S_ISSUE: begin
        state_d = bus.flush ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (wd_expired_c) begin
          state_d = S_IDLE;
        end else if (bus.div_res_valid) begin
          if (bus.flush) begin
            state_d = S_IDLE;
          end else begin
            res_data_d = op_mod_q ? bus.div_res[XLEN-1:0] : bus.div_res[2*XLEN-1:XLEN];
            state_d    = S_DONE;
          end
        end else if (bus.flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (wd_expired_c || bus.div_res_valid) begin
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        if (bus.res_ready || bus.flush) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Watchdog restarts on every entry into WAIT or DRAIN; registered status outputs
  always_comb begin
    in_wd_d     = (state_d == S_WAIT) || (state_d == S_DRAIN);
    wd_cnt_d    = (in_wd_d && (state_d == state_q)) ? wd_cnt_q + CNT_W'(1) : '0;
    timeout_d   = in_wd_d && (wd_cnt_d == CNT_W'(MAX_CYCLES));
    div_en_d    = (state_d == S_ISSUE);
    res_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      op_mod_q     <= 1'b0;
      div_signed_q <= 1'b0;
      div_src1_q   <= '0;
      div_src2_q   <= '0;
      res_data_q   <= '0;
      wd_cnt_q     <= '0;
      div_en_q     <= 1'b0;
      res_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_mod_q     <= op_mod_d;
      div_signed_q <= div_signed_d;
      div_src1_q   <= div_src1_d;
      div_src2_q   <= div_src2_d;
      res_data_q   <= res_data_d;
      wd_cnt_q     <= wd_cnt_d;
      div_en_q     <= div_en_d;
      res_valid_q  <= res_valid_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.div_en     = div_en_q;
  assign bus.div_signed = div_signed_q;
  assign bus.div_src1   = div_src1_q;
  assign bus.div_src2   = div_src2_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign busy           = busy_q;
  assign timeout        = timeout_q;
endmodule

// File: tb/tb_div_sched.sv
// Self-checking bench for div_sched: the bench plays EX, the divider and the consumer,
// and compares against an arithmetic reference of divide/modulo semantics.
module tb_div_sched;
  logic clk;
  logic resetn;
  logic busy;
  logic timeout;
  int   n_tests;
  int   n_fail;

  div_sched_if bus ();

  div_sched #(.MAX_CYCLES(40)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .bus     (bus),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference quotient/remainder (signed truncates toward zero; MIN/-1 overflows to MIN rem 0)
  function automatic logic [63:0] ref_qr(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a;
        r = '0;
      end else begin
        q = 32'($signed(a) / $signed(b));
        r = 32'($signed(a) % $signed(b));
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  function automatic logic [31:0] ref_result(input logic mod, input logic sgn,
                                             input logic [31:0] a, input logic [31:0] b);
    logic [63:0] qr;
    if (b == 32'd0) return mod ? a : 32'hFFFF_FFFF;
    qr = ref_qr(sgn, a, b);
    return mod ? qr[31:0] : qr[63:32];
  endfunction

  task automatic drive_req(input logic mod, input logic sgn, input logic [31:0] a, input logic [31:0] b);
    bus.req_valid  = 1'b1;
    bus.req_op_mod = mod;
    bus.req_signed = sgn;
    bus.req_src1   = a;
    bus.req_src2   = b;
  endtask

  // One complete operation; divider answers lat cycles after div_en, consumer stalls hold cycles
  task automatic do_op(input logic mod, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input int hold);
    logic [31:0] exp_r;
    int          en_cnt;
    logic        stable;
    exp_r = ref_result(mod, sgn, a, b);
    drive_req(mod, sgn, a, b);
    #1;
    check_eq("req_ready_idle", 64'(bus.req_ready), 64'd1);
    tick();
    bus.req_valid = 1'b0;
    en_cnt = 0;
    if (b != 32'd0) begin
      check_eq("issue_src1", 64'(bus.div_src1), 64'(a));
      check_eq("issue_src2", 64'(bus.div_src2), 64'(b));
      check_eq("issue_signed", 64'(bus.div_signed), 64'(sgn));
      en_cnt += int'(bus.div_en);
      for (int i = 0; i < lat; i++) begin
        tick();
        en_cnt += int'(bus.div_en);
      end
      check_eq("wait_no_res", 64'(bus.res_valid), 64'd0);
      bus.div_res_valid = 1'b1;
      bus.div_res       = ref_qr(bus.div_signed, bus.div_src1, bus.div_src2);
      tick();
      bus.div_res_valid = 1'b0;
      bus.div_res       = {$urandom, $urandom};
      en_cnt += int'(bus.div_en);
      check_eq("div_en_once", 64'(en_cnt), 64'd1);
    end else begin
      check_eq("bypass_no_div_en", 64'(bus.div_en), 64'd0);
    end
    check_eq("res_valid", 64'(bus.res_valid), 64'd1);
    check_eq("res_data", 64'(bus.res_data), 64'(exp_r));
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      if (bus.res_valid !== 1'b1 || bus.res_data !== exp_r || bus.req_ready !== 1'b0) stable = 1'b0;
      tick();
    end
    if (hold > 0) check_eq("hold_stable", 64'(stable), 64'd1);
    bus.res_ready = 1'b1;
    #1;
    check_eq("done_req_ready", 64'(bus.req_ready), 64'd0);
    tick();
    bus.res_ready = 1'b0;
    #1;
    check_eq("post_res_valid", 64'(bus.res_valid), 64'd0);
    check_eq("post_busy", 64'(busy), 64'd0);
    check_eq("post_req_ready", 64'(bus.req_ready), 64'd1);
  endtask

  // Flush flush_at cycles after div_en; divider answers lat cycles after div_en
  task automatic flush_op(input int flush_at, input int lat);
    logic ok;
    drive_req(1'b0, 1'b0, 32'd1000, 32'd7);
    tick();
    bus.req_valid = 1'b0;
    ok = 1'b1;
    for (int i = 1; i <= lat; i++) begin
      tick();
      bus.flush         = 1'b0;
      bus.div_res_valid = 1'b0;
      if (i == flush_at) bus.flush = 1'b1;
      if (i == lat) begin
        bus.div_res_valid = 1'b1;
        bus.div_res       = ref_qr(bus.div_signed, bus.div_src1, bus.div_src2);
      end
      #1;
      if (bus.req_ready !== 1'b0 || bus.res_valid !== 1'b0 || busy !== 1'b1) ok = 1'b0;
    end
    tick();
    bus.flush         = 1'b0;
    bus.div_res_valid = 1'b0;
    #1;
    check_eq("flush_blocked", 64'(ok), 64'd1);
    check_eq("flush_res_valid", 64'(bus.res_valid), 64'd0);
    check_eq("flush_busy", 64'(busy), 64'd0);
    check_eq("flush_req_ready", 64'(bus.req_ready), 64'd1);
  endtask

  task automatic watchdog_op();
    int n;
    int pulses;
    drive_req(1'b0, 1'b1, 32'd55, 32'd3);
    tick();
    bus.req_valid = 1'b0;
    n = 0;
    while (timeout !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    // div_en cycle is n=0, WAIT entry n=1, expiry 40 cycles after WAIT entry
    check_eq("wd_cycles", 64'(n), 64'd41);
    check_eq("wd_busy_during", 64'(busy), 64'd1);
    pulses = int'(timeout);
    tick();
    pulses += int'(timeout);
    check_eq("wd_single_pulse", 64'(pulses), 64'd1);
    check_eq("wd_busy_after", 64'(busy), 64'd0);
    check_eq("wd_no_res", 64'(bus.res_valid), 64'd0);
    check_eq("wd_req_ready", 64'(bus.req_ready), 64'd1);
  endtask

  task automatic reset_mid_wait();
    drive_req(1'b1, 1'b0, 32'd999, 32'd10);
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    tick();
    check_eq("rst_pre_busy", 64'(busy), 64'd1);
    #2;
    resetn = 1'b0;
    #1;
    check_eq("rst_async_busy", 64'(busy), 64'd0);
    check_eq("rst_async_res_valid", 64'(bus.res_valid), 64'd0);
    check_eq("rst_async_div_en", 64'(bus.div_en), 64'd0);
    check_eq("rst_async_src1", 64'(bus.div_src1), 64'd0);
    tick();
    tick();
    resetn = 1'b1;
    tick();
    do_op(1'b1, 1'b0, 32'd999, 32'd10, 5, 1);
  endtask

  function automatic logic [31:0] pick_operand(input bit divisor);
    unique case ($urandom_range(0, 5))
      0: return divisor ? 32'd0 : 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(1, 20));
      3: return divisor ? 32'd1 : 32'd0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    n_tests           = 0;
    n_fail            = 0;
    clk               = 1'b0;
    resetn            = 1'b0;
    bus.req_valid     = 1'b0;
    bus.req_op_mod    = 1'b0;
    bus.req_signed    = 1'b0;
    bus.req_src1      = '0;
    bus.req_src2      = '0;
    bus.flush         = 1'b0;
    bus.div_res_valid = 1'b0;
    bus.div_res       = '0;
    bus.res_ready     = 1'b0;

    tick();
    tick();
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_div_en", 64'(bus.div_en), 64'd0);
    check_eq("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check_eq("rst_timeout", 64'(timeout), 64'd0);
    check_eq("rst_res_data", 64'(bus.res_data), 64'd0);
    check_eq("rst_div_src", {bus.div_src1, bus.div_src2}, 64'd0);
    check_eq("rst_div_signed", 64'(bus.div_signed), 64'd0);
    resetn = 1'b1;
    tick();
    check_eq("rst_req_ready", 64'(bus.req_ready), 64'd1);
    bus.flush = 1'b1;
    #1;
    check_eq("flush_gates_ready", 64'(bus.req_ready), 64'd0);
    bus.flush = 1'b0;
    tick();

    do_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 17, 0);
    check_eq("sdiv_known", 64'(ref_result(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2)), 64'hFFFF_FFFD);
    do_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'd10, 6, 4);
    do_op(1'b0, 1'b0, 32'd100, 32'd0, 0, 0);
    do_op(1'b1, 1'b0, 32'd100, 32'd0, 0, 2);
    do_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
    flush_op(5, 17);
    flush_op(17, 17);
    flush_op(1, 3);
    watchdog_op();
    reset_mid_wait();

    for (int k = 0; k < 150; k++) begin
      do_op(1'($urandom), 1'($urandom), pick_operand(1'b0), pick_operand(1'b1),
            $urandom_range(1, 20), $urandom_range(0, 3));
      for (int j = $urandom_range(0, 2); j > 0; j--) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
